// File: rtl/ext_msg_reader.sv
// ext_msg_reader: read-only burst master that streams words out of the
// extrinsic message RAM. A burst of len_m1+1 reads starts at base_addr,
// with the address wrapping at the end of the RAM. The read data lands in a
// 2-entry output FIFO, and the FIFO drives a valid/ready stream. Reads are
// throttled so that the FIFO can never overflow. With m_ready held high the
// block still moves one word per cycle.
module ext_msg_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] len_m1,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_chip_sel,
   output logic                  ram_write_en,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;     // reads still to issue
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d; // address of next read
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d; // address of last issued read
   logic                  infl_q, infl_last_q;      // read issued last cycle (+ its last tag)
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic                  fifo_last_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            cnt_q, cnt_d;
   logic                  done_q;

   logic                  pop, issue, last_issue;
   logic [1:0]            occ;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: leave READ once the final read goes out, leave DRAIN on the last handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_READ;
         S_READ:  if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (pop && m_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs and read gating: a read may issue only if buffered + in-flight words, less a same-cycle pop, stay below 2
   always_comb begin
      busy         = (state_q != S_IDLE);
      done         = done_q;
      m_valid      = (cnt_q != 2'd0);
      m_data       = m_valid ? fifo_data_q[rd_ptr_q] : '0;
      m_last       = m_valid & fifo_last_q[rd_ptr_q];
      pop          = m_valid & m_ready;
      occ          = cnt_q + {1'b0, infl_q};
      issue        = (state_q == S_READ) && (rd_left_q != '0) && (occ < (2'd2 + {1'b0, pop}));
      last_issue   = issue && (rd_left_q == CNT_ONE);
      ram_chip_sel = issue;
      ram_address  = issue ? next_addr_q : last_addr_q;
      ram_write_en = 1'b0;
      ram_data_in  = '0;
   end

   // Datapath next-state: burst setup on start, address/count advance per issued read, FIFO occupancy
   always_comb begin
      next_addr_d = next_addr_q;
      last_addr_d = last_addr_q;
      rd_left_d   = rd_left_q;
      if (state_q == S_IDLE && start) begin
         next_addr_d = base_addr;
         rd_left_d   = {1'b0, len_m1} + CNT_ONE;
      end
      if (issue) begin
         last_addr_d = next_addr_q;
         next_addr_d = next_addr_q + ADDR_ONE;
         rd_left_d   = rd_left_q - CNT_ONE;
      end
      case ({infl_q, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Datapath registers: capture read data the cycle after its strobe, pop on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_left_q   <= '0;
         next_addr_q <= '0;
         last_addr_q <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         done_q      <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         rd_left_q   <= rd_left_d;
         next_addr_q <= next_addr_d;
         last_addr_q <= last_addr_d;
         infl_q      <= issue;
         infl_last_q <= last_issue;
         cnt_q       <= cnt_d;
         done_q      <= (state_q == S_DRAIN) && pop && m_last;
         if (infl_q) begin
            fifo_data_q[wr_ptr_q] <= ram_data_out;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule

// File: tb/tb_ext_msg_reader.sv
// Bench for ext_msg_reader. It contains a behavioural RAM and a per-burst
// reference model. The reference model works out the expected words as
// mem[(base+k) mod 256], and only word len_m1 carries the last flag. The
// bench also enforces three more rules: read count, stall stability, and the
// occupancy bound.
module tb_ext_msg_reader;

   logic       clk = 1'b0;
   logic       rst_n, start, m_ready;
   logic [7:0] base_addr, len_m1;
   logic       busy, done, ram_chip_sel, ram_write_en, m_valid, m_last;
   logic [7:0] ram_address, ram_data_in, ram_data_out, m_data;

   logic [7:0] mem [256];
   logic [7:0] ram_q = 8'h00;
   int         n_cmp = 0, n_err = 0;

   ext_msg_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_m1(len_m1),
      .busy(busy), .done(done), .ram_address(ram_address), .ram_chip_sel(ram_chip_sel),
      .ram_write_en(ram_write_en), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM: data valid the cycle after the strobe
   always @(posedge clk) if (ram_chip_sel) ram_q <= mem[ram_address];
   assign ram_data_out = ram_q;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // rmode: 0 = ready always 1 (exact timing checked), 1 = random ready + stray starts,
   //        2 = ready low in cycles 3..10
   task automatic run_burst(input logic [7:0] base, input logic [7:0] len, input int rmode);
      int cyc = 0, rd_n = 0, acc_n = 0, last_cyc = -10, L;
      logic pv = 1'b0, pr = 1'b1, pl = 1'b0, hs;
      logic [7:0] pd = 8'h00, exp_a;
      L = int'(len);
      start = 1'b1; base_addr = base; len_m1 = len; m_ready = 1'b1;
      do begin
         @(posedge clk); #1; cyc++;
         if (cyc - 1 == last_cyc) start = 1'b0;
         else if (rmode == 1 && $urandom_range(0, 5) == 0) begin
            start = 1'b1; base_addr = 8'($urandom); len_m1 = 8'($urandom);
         end else start = 1'b0;
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 2) != 0);
            default: m_ready = !(cyc >= 3 && cyc <= 10);
         endcase
         @(negedge clk);
         if (rmode == 0) begin
            chk("sel_timing", ram_chip_sel, cyc <= L + 1);
            chk("valid_timing", m_valid, cyc >= 3 && cyc <= L + 3);
         end
         chk("busy", busy, cyc != last_cyc + 1);
         chk("done", done, cyc == last_cyc + 1);
         if (ram_chip_sel) begin
            exp_a = base + rd_n[7:0];
            chk("addr", ram_address, exp_a);
            rd_n++;
         end
         hs = m_valid & m_ready;
         chk("occupancy", (rd_n - acc_n - int'(hs)) <= 2, 1);
         if (pv && !pr) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, pd);
            chk("stall_last", m_last, pl);
         end
         if (hs) begin
            exp_a = base + acc_n[7:0];
            chk("data", m_data, mem[exp_a]);
            chk("last", m_last, acc_n == L);
            if (acc_n == L) last_cyc = cyc;
            acc_n++;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
         if (cyc > 4 * L + 200) begin
            chk("timeout", 0, 1);
            break;
         end
      end while (cyc != last_cyc + 1);
      start = 1'b0;
      chk("num_reads", rd_n, L + 1);
      chk("num_words", acc_n, L + 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = 8'h00; len_m1 = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      chk("rst_sel", ram_chip_sel, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_we", ram_write_en, 0);
      chk("rst_din", ram_data_in, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed scenarios
      run_burst(8'h10, 8'd3, 0);
      run_burst(8'hFE, 8'd3, 0);
      run_burst(8'h20, 8'd7, 2);
      run_burst(8'h05, 8'd0, 0);  // starts in the previous burst's done cycle
      run_burst(8'h60, 8'd5, 1);  // stray start pulses during the burst

      // reset in cycle 4 of a len_m1=7 burst
      start = 1'b1; base_addr = 8'h30; len_m1 = 8'd7; m_ready = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_sel", ram_chip_sel, 0);
      chk("mid_rst_addr", ram_address, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_burst(8'h40, 8'd1, 0);

      // random contents, bases, lengths and back-pressure
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int n = 0; n < 30; n++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("idle_sel", ram_chip_sel, 0);
            chk("idle_busy", busy, 0);
         end
         run_burst(8'($urandom), (n == 0) ? 8'd255 : 8'($urandom_range(0, 12)), (n % 3 == 0) ? 0 : 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
